// File: rtl/spi_arbiter.sv
// Round-robin sequencer that shares one SPI engine between NREQ requesters.
// It owns the chip selects and the start/done handshake, plus the setup, guard and timeout intervals.
module spi_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 16,
  parameter int SETUP_CYC = 1,
  parameter int GUARD_CYC = 2,
  parameter int TIMEOUT   = 64
) (
  input  logic               clk,
  input  logic               reset_l,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    done,
  output logic [NREQ-1:0]    err,
  output logic               spi_start,
  output logic [DW-1:0]      spi_word,
  input  logic               spi_busy,
  input  logic               spi_done,
  output logic [NREQ-1:0]    dev_cs_l,
  output logic               busy
);

  // state    | meaning
  // ST_IDLE  | no transfer; arbitrate pending requests
  // ST_SETUP | cs low, counting setup, then waiting for an idle engine
  // ST_WAIT  | engine launched; waiting for spi_done or timeout
  // ST_GUARD | all cs high for GUARD_CYC cycles before the next arbitration
  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_WAIT, ST_GUARD} state_t;

  localparam int M1      = (SETUP_CYC > GUARD_CYC) ? SETUP_CYC : GUARD_CYC;
  localparam int CNT_MAX = (TIMEOUT > M1) ? TIMEOUT : M1;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int LW      = $clog2(NREQ);

  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC);
  localparam logic [CW-1:0] GUARD_LD = CW'(GUARD_CYC - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [LW-1:0] LAST_RST = LW'(NREQ - 1);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [LW-1:0]     last_q, last_d;
  logic [DW-1:0]     word_q, word_d;
  logic [NREQ-1:0]   cs_q, cs_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [NREQ-1:0]   err_q, err_d;
  logic              start_q, start_d;
  logic              busy_q, busy_d;

  logic              found;
  logic [LW-1:0]     win;
  int                idx;

  // Rotating priority: first set request after the previous winner.
  always_comb begin
    found = 1'b0;
    win   = last_q;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(last_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[LW'(idx)]) begin
        found = 1'b1;
        win   = LW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    word_d  = word_q;
    cs_d    = cs_q;
    gnt_d   = '0;
    done_d  = '0;
    err_d   = '0;
    start_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          gnt_d[win] = 1'b1;
          word_d     = req_data[int'(win)*DW +: DW];
          cs_d       = '1;
          cs_d[win]  = 1'b0;
          last_d     = win;
          cnt_d      = SETUP_LD;
          state_d    = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!spi_busy) begin
          start_d = 1'b1;
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Completion takes precedence over a timeout on the same edge.
        if (spi_done) begin
          done_d[last_q] = 1'b1;
          cs_d           = '1;
          cnt_d          = GUARD_LD;
          state_d        = ST_GUARD;
        end else if (TIMEOUT > 0 && cnt_q == TO_LAST) begin
          err_d[last_q] = 1'b1;
          cs_d          = '1;
          cnt_d         = GUARD_LD;
          state_d       = ST_GUARD;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_GUARD: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= LAST_RST;
      word_q  <= '0;
      cs_q    <= '1;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      word_q  <= word_d;
      cs_q    <= cs_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      start_q <= start_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign err       = err_q;
  assign spi_start = start_q;
  assign spi_word  = word_q;
  assign dev_cs_l  = cs_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter at default parameters; the bench plays the SPI engine.
module tb_spi_arbiter;

  logic        clk = 1'b0;
  logic        reset_l;
  logic [3:0]  req;
  logic [63:0] req_data;
  logic [3:0]  gnt, done, err, dev_cs_l;
  logic        spi_start, spi_busy, spi_done, busy;
  logic [15:0] spi_word;

  logic [15:0] data [4];
  int errors = 0;
  int checks = 0;

  spi_arbiter dut (
    .clk(clk), .reset_l(reset_l), .req(req), .req_data(req_data),
    .gnt(gnt), .done(done), .err(err), .spi_start(spi_start),
    .spi_word(spi_word), .spi_busy(spi_busy), .spi_done(spi_done),
    .dev_cs_l(dev_cs_l), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_gnt(output int n);
    n = 0;
    while (gnt === 4'b0 && n < 200) begin
      step();
      n++;
    end
  endtask

  task automatic xfer(input int idx, input int dly, output int gap);
    int n;
    logic [3:0] one, cs_exp;
    one    = 4'b0001 << idx;
    cs_exp = ~one;
    wait_gnt(gap);
    chk("rr_gnt", gnt, one);
    chk("rr_cs_low", dev_cs_l, cs_exp);
    n = 0;
    while (spi_start !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("rr_start_lat", n, 2);
    chk("rr_word", spi_word, data[idx]);
    repeat (dly - 1) step();
    spi_done = 1'b1;
    step();
    spi_done = 1'b0;
    chk("rr_done", done, one);
    chk("rr_cs_high", dev_cs_l, 4'hF);
  endtask

  initial begin
    int n, gap, bad;
    data[0] = 16'hA5C3; data[1] = 16'h1234; data[2] = 16'h5A0F; data[3] = 16'hBEEF;
    req_data = {data[3], data[2], data[1], data[0]};
    reset_l = 1'b0; req = 4'b0; spi_busy = 1'b0; spi_done = 1'b0;
    repeat (2) step();
    chk("rst_gnt", gnt, 4'h0);
    chk("rst_cs", dev_cs_l, 4'hF);
    chk("rst_word", spi_word, 16'h0);
    chk("rst_busy", {busy, spi_start, done, err}, 9'h0);
    reset_l = 1'b1;
    step();

    // single request
    req = 4'b0001;
    step();
    chk("t1_gnt", gnt, 4'b0001);
    chk("t1_cs", dev_cs_l, 4'b1110);
    chk("t1_word", spi_word, 16'hA5C3);
    chk("t1_busy", busy, 1'b1);
    req = 4'b0;
    step();
    chk("t1_gnt_pulse", gnt, 4'b0000);
    chk("t1_no_start_e1", spi_start, 1'b0);
    step();
    chk("t1_start", spi_start, 1'b1);
    chk("t1_start_word", spi_word, 16'hA5C3);
    step();
    chk("t1_start_pulse", spi_start, 1'b0);
    repeat (32) step();
    spi_done = 1'b1;
    step();
    spi_done = 1'b1;
    chk("t1_done", done, 4'b0001);
    chk("t1_cs_high", dev_cs_l, 4'hF);
    chk("t1_no_err", err, 4'b0);
    step();
    spi_done = 1'b0;
    chk("guard_spur_done", {done, err}, 8'h0);
    chk("guard_busy", busy, 1'b1);
    step();
    chk("idle_after_guard", busy, 1'b0);
    spi_done = 1'b1;
    step();
    spi_done = 1'b0;
    chk("idle_spur_done", {done, err, gnt}, 12'h0);
    chk("idle_spur_busy", busy, 1'b0);

    // round robin from a fresh pointer
    reset_l = 1'b0;
    step();
    reset_l = 1'b1;
    req = 4'b1111;
    xfer(0, 3, gap);
    xfer(1, 5, gap);
    chk("rr_gap1", gap, 3);
    xfer(2, 1, gap);
    chk("rr_gap2", gap, 3);
    xfer(3, 2, gap);
    chk("rr_gap3", gap, 3);
    xfer(0, 4, gap);
    chk("rr_gap4", gap, 3);
    req = 4'b0;

    // engine busy holds SETUP
    step(); step(); step();
    req = 4'b0100;
    wait_gnt(n);
    chk("busy_gnt", gnt, 4'b0100);
    spi_busy = 1'b1;
    req = 4'b0;
    bad = 0;
    repeat (11) begin
      step();
      if (spi_start !== 1'b0 || dev_cs_l !== 4'b1011) bad++;
    end
    chk("busy_hold", bad, 0);
    spi_busy = 1'b0;
    step();
    chk("busy_start", spi_start, 1'b1);
    spi_done = 1'b1;
    step();
    spi_done = 1'b0;
    chk("busy_done", done, 4'b0100);

    // timeout, then pending request granted, then done on the last cycle
    req = 4'b1010;
    wait_gnt(n);
    chk("to_gnt", gnt, 4'b1000);
    req = 4'b0010;
    n = 0;
    while (spi_start !== 1'b1 && n < 20) begin step(); n++; end
    chk("to_start", spi_start, 1'b1);
    bad = 0;
    repeat (63) begin
      step();
      if (err !== 4'b0 || done !== 4'b0 || dev_cs_l !== 4'b0111) bad++;
    end
    chk("to_quiet", bad, 0);
    step();
    chk("to_err", err, 4'b1000);
    chk("to_no_done", done, 4'b0);
    chk("to_cs", dev_cs_l, 4'hF);
    step();
    chk("to_err_pulse", err, 4'b0);
    wait_gnt(n);
    chk("to_next_gnt", gnt, 4'b0010);
    req = 4'b0;
    n = 0;
    while (spi_start !== 1'b1 && n < 20) begin step(); n++; end
    chk("to2_start", spi_start, 1'b1);
    repeat (63) step();
    spi_done = 1'b1;
    step();
    spi_done = 1'b0;
    chk("to2_done", done, 4'b0010);
    chk("to2_no_err", err, 4'b0);

    // request withdrawn during GUARD is never granted
    req = 4'b0001;
    step();
    req = 4'b0;
    bad = 0;
    repeat (4) begin
      step();
      if (gnt !== 4'b0) bad++;
    end
    chk("withdrawn_no_gnt", bad, 0);

    // reset mid-WAIT
    req = 4'b0010;
    wait_gnt(n);
    req = 4'b0;
    repeat (4) step();
    chk("rw_cs", dev_cs_l, 4'b1101);
    chk("rw_busy", busy, 1'b1);
    #2;
    reset_l = 1'b0;
    #1;
    chk("rw_async_cs", dev_cs_l, 4'hF);
    chk("rw_async_word", spi_word, 16'h0);
    chk("rw_async_busy", {busy, spi_start, gnt, done, err}, 13'h0);
    step();
    reset_l = 1'b1;
    req = 4'b0010;
    step();
    chk("rw_regnt", gnt, 4'b0010);
    chk("rw_regnt_cs", dev_cs_l, 4'b1101);
    chk("rw_no_done_err", {done, err}, 8'h0);
    req = 4'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_arbiter.md
# spi_arbiter

Round-robin arbiter and sequencer that shares one SPI shift engine between up to NREQ requesters, each with its own slave device. It sits between the requesters (DAC/config channels) and the SPI master. It captures the winning requester's word and drives that device's active-low chip select. It launches the engine with a start/done handshake, then enforces setup, guard and timeout intervals.

## Interface
- NREQ, 4, number of requesters/devices (2..8)
- DW, 16, SPI word width
- SETUP_CYC, 1, cycles between chip-select fall and spi_start (>=1)
- GUARD_CYC, 2, cycles chip selects stay high after a transfer before the next arbitration (>=1)
- TIMEOUT, 64, max WAIT cycles without spi_done before abort; 0 disables
- clk  in  1  system clock, all logic on rising edge
- reset_l  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester transfer request (level)
- req_data  in  NREQ*DW  request words, requester i at bits [i*DW +: DW]
- gnt  out  NREQ  one-cycle pulse: requester's word captured
- done  out  NREQ  one-cycle pulse: requester's transfer completed
- err  out  NREQ  one-cycle pulse: requester's transfer aborted by timeout
- spi_start  out  1  one-cycle launch pulse to SPI engine
- spi_word  out  DW  word presented to the engine, stable from grant to end of WAIT
- spi_busy  in  1  engine busy
- spi_done  in  1  engine completion pulse
- dev_cs_l  out  NREQ  per-device active-low chip select
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, SETUP, WAIT, GUARD.
- Reset values:
  - gnt, done, err, spi_start and busy = 0.
  - spi_word = 0 and dev_cs_l = all ones.
  - State = IDLE; round-robin pointer last = NREQ-1, so requester 0 has first priority.
- IDLE: if any req bit is high at an edge, choose winner w as the first set bit scanning last+1, last+2, ... (mod NREQ). On that edge:
  - gnt[w]=1 for one cycle.
  - spi_word = req_data slice w.
  - dev_cs_l[w]=0; last=w; state becomes SETUP.
- req_data is sampled only at the grant edge. A requester deasserts req after seeing gnt; a req dropped before grant is withdrawn with no side effect.
- SETUP: stays for SETUP_CYC cycles. After that, on the first edge with spi_busy=0, spi_start=1 for one cycle and the state becomes WAIT. While spi_busy=1 the block remains in SETUP with cs held low.
- WAIT: the timeout counter clears on entry and increments each WAIT cycle.
  - spi_done=1 at an edge: done[w]=1 for one cycle, dev_cs_l = all ones, state becomes GUARD.
  - Counter reaches TIMEOUT (TIMEOUT>0) without spi_done: err[w]=1 for one cycle, dev_cs_l = all ones, state becomes GUARD.
  - spi_done and timeout on the same edge: done wins and err stays 0.
- GUARD: stays for GUARD_CYC cycles with all chip selects high, then returns to IDLE. req is ignored outside IDLE and stays pending.
- spi_done outside WAIT is ignored. At most one dev_cs_l bit is ever low.
- Counter widths are sized to hold max(SETUP_CYC, GUARD_CYC, TIMEOUT) with no wrap.
- Reset asserted mid-transfer forces all outputs to their reset values immediately (asynchronously). No done or err is issued for the aborted transfer.

## Timing
- Grant: req high before edge E0 in IDLE gives gnt, cs low and spi_word valid from E0.
- Launch: with spi_busy=0, spi_start is high for the cycle after E0+SETUP_CYC, i.e. SETUP_CYC+1 cycles after cs falls.
- Completion: spi_done sampled at edge En gives done and cs high from En.
- Back-to-back: the earliest next gnt/cs fall is at edge En+GUARD_CYC+1, so the minimum cs-high gap is GUARD_CYC+1 cycles.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Single request, defaults: req=0001, data0=16'hA5C3.
  - gnt[0] pulses at E0 and dev_cs_l=1110.
  - spi_start is one cycle, 2 cycles after cs fall, with spi_word=A5C3.
  - Engine spi_done 34 cycles later gives done[0] pulse and dev_cs_l=1111.
- Round-robin: req=1111 held continuously. Grants occur in order 0,1,2,3,0, each transfer separated by exactly GUARD_CYC+1=3 cs-high cycles.
- Busy engine: spi_busy=1 for 10 cycles after SETUP. The block stays in SETUP with cs low and no spi_start; spi_start fires on the first edge with spi_busy=0.
- Timeout: spi_done never returns, TIMEOUT=64.
  - err[w] pulses after 64 WAIT cycles, with no done and cs high.
  - Next pending request is granted normally.
  - Second case: spi_done on the 64th cycle gives done and no err.
- Reset mid-WAIT: reset_l low while dev_cs_l=1101. All outputs return to reset values asynchronously. After release with req=0010, requester 1 is granted (pointer reset, req0 low).
- Ignored inputs: a spurious spi_done pulse in IDLE and in GUARD causes no done, err or state change. A req dropped before grant causes no gnt.
